// File: rtl/uart_pkg.sv
// Shared types, widths and defaults for the UART receive front end.
package uart_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 87;
    localparam int DEFAULT_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } framer_state_e;

    // Smallest n with 2**n >= value; used for counter and address widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; head is read straight from the storage flops.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_W,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot being written, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            // NOTE: storage is reset on purpose so the head byte reads 0x00 out of reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[ADDR_W-1:0]] <= push_data;
                wr_ptr                  <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: line synchronizer, mid-bit sampling framer and byte FIFO
// with a valid/ready read side and single-cycle error pulses.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   busy
);

    localparam int               CNT_W    = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]             rst_sync;
    logic                   rst_int_n;
    logic                   rx_meta;
    logic                   rx_s;
    framer_state_e          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   push;
    logic                   stop_bad;
    logic                   pop;
    logic                   full;
    logic                   empty;

    // Reset asserts asynchronously but releases two clocks later, on an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make this a true two-flop chain.
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q - CNT_ONE;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push     = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    state_d = rx_s ? IDLE : DATA;
                    cnt_d   = CNT_BIT;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[UART_DATA_W-1:1]};
                    cnt_d   = CNT_BIT;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    push     = rx_s;
                    stop_bad = !rx_s;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Disabling drops any partial frame silently.
        if (!ena) begin
            state_d  = IDLE;
            push     = 1'b0;
            stop_bad = 1'b0;
        end
    end

    assign rx_valid = !empty;
    assign pop      = rx_valid && rx_ready;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= push && full && !pop;
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .push      (push),
        .push_data (shift_q),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (rx_data)
    );

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at 8 clocks per bit and a 4-deep FIFO.
module tb_uart_rx_frontend;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    // Start edge driven to rx_valid: 2 sync + 1 detect + half bit + 8 data + stop.
    localparam int LAT   = 3 + CPB / 2 + 9 * CPB;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int passed   = 0;
    int total    = 0;
    int cyc      = 0;
    int vcount   = 0;
    int ferr_n   = 0;
    int ovr_n    = 0;
    int ferr_cyc = -1;
    int ovr_cyc  = -1;
    logic [7:0] pop_q[$];
    int         pop_cyc_q[$];

    uart_rx_frontend #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid) vcount <= vcount + 1;
        if (rx_valid && rx_ready) begin
            pop_q.push_back(rx_data);
            pop_cyc_q.push_back(cyc);
        end
        if (frame_err) begin
            ferr_n   <= ferr_n + 1;
            ferr_cyc <= cyc;
        end
        if (overrun) begin
            ovr_n   <= ovr_n + 1;
            ovr_cyc <= cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge ending the stop bit.
    task automatic send_byte(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        ena      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        #3;
        total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h, expected 00", rx_data); else passed++;
        total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b, expected 0", rx_valid); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b, expected 0", frame_err); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b, expected 0", overrun); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else passed++;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(4);
        @(negedge clk);
        total++; if (rx_valid !== 1'b0) $display("FAIL release_rx_valid: got %b, expected 0", rx_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL release_busy: got %b, expected 0", busy); else passed++;
        tick(1);
    endtask

    task automatic test_single_frame();
        int c0, vb, pb, fb, ob;
        rx_ready = 1'b1;
        vb = vcount; pb = pop_q.size(); fb = ferr_n; ob = ovr_n;
        c0 = cyc;
        send_byte(8'hA5, 1'b1);
        tick(4);
        total++; if (vcount - vb !== 1) $display("FAIL single_valid_cycles: got %0d, expected 1", vcount - vb); else passed++;
        total++; if (pop_q.size() - pb !== 1) $display("FAIL single_pop_count: got %0d, expected 1", pop_q.size() - pb); else passed++;
        if (pop_q.size() > pb) begin
            total++; if (pop_q[pb] !== 8'hA5) $display("FAIL single_data: got %h, expected a5", pop_q[pb]); else passed++;
            total++; if (pop_cyc_q[pb] !== c0 + LAT) $display("FAIL single_latency: got cycle %0d, expected %0d", pop_cyc_q[pb], c0 + LAT); else passed++;
        end
        total++; if (ferr_n - fb !== 0 || ovr_n - ob !== 0) $display("FAIL single_pulses: got ferr %0d ovr %0d, expected 0 0", ferr_n - fb, ovr_n - ob); else passed++;
    endtask

    task automatic test_overrun();
        int c0, pb, fb, ob;
        rx_ready = 1'b0;
        fb = ferr_n; ob = ovr_n;
        c0 = cyc;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        total++; if (ovr_n - ob !== 1) $display("FAIL ovr_count: got %0d, expected 1", ovr_n - ob); else passed++;
        total++; if (ovr_cyc !== c0 + 4 * FRAME + LAT) $display("FAIL ovr_cycle: got %0d, expected %0d", ovr_cyc, c0 + 4 * FRAME + LAT); else passed++;
        total++; if (ferr_n - fb !== 0) $display("FAIL ovr_no_ferr: got %0d, expected 0", ferr_n - fb); else passed++;
        tick(3);
        @(negedge clk);
        total++; if (rx_valid !== 1'b1) $display("FAIL ovr_hold_valid: got %b, expected 1", rx_valid); else passed++;
        total++; if (rx_data !== 8'h01) $display("FAIL ovr_hold_data: got %h, expected 01", rx_data); else passed++;
        tick(1);
        pb = pop_q.size();
        rx_ready = 1'b1;
        tick(8);
        total++; if (pop_q.size() - pb !== 4) $display("FAIL ovr_drain_count: got %0d, expected 4", pop_q.size() - pb); else passed++;
        if (pop_q.size() - pb >= 4) begin
            for (int i = 0; i < 4; i++) begin
                total++; if (pop_q[pb + i] !== 8'(i + 1)) $display("FAIL ovr_drain_data%0d: got %h, expected %h", i, pop_q[pb + i], 8'(i + 1)); else passed++;
            end
            total++; if (pop_cyc_q[pb + 3] - pop_cyc_q[pb] !== 3) $display("FAIL ovr_drain_span: got %0d cycles, expected 3", pop_cyc_q[pb + 3] - pop_cyc_q[pb]); else passed++;
        end
        @(negedge clk);
        total++; if (rx_valid !== 1'b0) $display("FAIL ovr_empty: got %b, expected 0", rx_valid); else passed++;
        tick(1);
    endtask

    task automatic test_frame_error();
        int c0, vb, pb, fb, ob;
        rx_ready = 1'b1;
        vb = vcount; pb = pop_q.size(); fb = ferr_n; ob = ovr_n;
        c0 = cyc;
        send_byte(8'h3C, 1'b0);
        rx = 1'b1;
        tick(20);
        total++; if (ferr_n - fb !== 1) $display("FAIL ferr_count: got %0d, expected 1", ferr_n - fb); else passed++;
        total++; if (ferr_cyc !== c0 + LAT) $display("FAIL ferr_cycle: got %0d, expected %0d", ferr_cyc, c0 + LAT); else passed++;
        total++; if (vcount - vb !== 0) $display("FAIL ferr_no_valid: got %0d, expected 0", vcount - vb); else passed++;
        send_byte(8'h7E, 1'b1);
        tick(4);
        total++; if (pop_q.size() - pb !== 1) $display("FAIL ferr_next_count: got %0d, expected 1", pop_q.size() - pb); else passed++;
        if (pop_q.size() > pb) begin
            total++; if (pop_q[pb] !== 8'h7E) $display("FAIL ferr_next_data: got %h, expected 7e", pop_q[pb]); else passed++;
        end
        total++; if (ferr_n - fb !== 1 || ovr_n - ob !== 0) $display("FAIL ferr_pulses: got ferr %0d ovr %0d, expected 1 0", ferr_n - fb, ovr_n - ob); else passed++;
    endtask

    task automatic test_glitch();
        int vb, fb, ob;
        vb = vcount; fb = ferr_n; ob = ovr_n;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL glitch_busy_high: got %b, expected 1", busy); else passed++;
        tick(6);
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL glitch_busy_low: got %b, expected 0", busy); else passed++;
        tick(4);
        total++; if (vcount - vb !== 0) $display("FAIL glitch_no_push: got %0d, expected 0", vcount - vb); else passed++;
        total++; if (ferr_n - fb !== 0 || ovr_n - ob !== 0) $display("FAIL glitch_pulses: got ferr %0d ovr %0d, expected 0 0", ferr_n - fb, ovr_n - ob); else passed++;
    endtask

    task automatic test_full_with_pop();
        int c4, pb, ob;
        rx_ready = 1'b0;
        ob = ovr_n;
        pb = pop_q.size();
        for (int i = 1; i <= 4; i++) send_byte(8'(16 * i), 1'b1);
        c4 = cyc;
        fork
            send_byte(8'h50, 1'b1);
            begin
                tick(LAT - 1);
                rx_ready = 1'b1;
            end
        join
        tick(8);
        total++; if (ovr_n - ob !== 0) $display("FAIL fullpop_no_overrun: got %0d, expected 0", ovr_n - ob); else passed++;
        total++; if (pop_q.size() - pb !== 5) $display("FAIL fullpop_count: got %0d, expected 5", pop_q.size() - pb); else passed++;
        if (pop_q.size() - pb >= 5) begin
            total++; if (pop_cyc_q[pb] !== c4 + LAT - 1) $display("FAIL fullpop_first_cycle: got %0d, expected %0d", pop_cyc_q[pb], c4 + LAT - 1); else passed++;
            for (int i = 0; i < 5; i++) begin
                total++; if (pop_q[pb + i] !== 8'(16 * (i + 1))) $display("FAIL fullpop_data%0d: got %h, expected %h", i, pop_q[pb + i], 8'(16 * (i + 1))); else passed++;
            end
        end
    endtask

    task automatic test_ena_abort();
        int vb, fb, ob;
        rx_ready = 1'b1;
        vb = vcount; fb = ferr_n; ob = ovr_n;
        fork
            send_byte(8'hFF, 1'b1);
            begin
                tick(30);
                @(negedge clk);
                total++; if (busy !== 1'b1) $display("FAIL ena_busy_before: got %b, expected 1", busy); else passed++;
                tick(1);
                ena = 1'b0;
                tick(1);
                @(negedge clk);
                total++; if (busy !== 1'b0) $display("FAIL ena_busy_after: got %b, expected 0", busy); else passed++;
            end
        join
        ena = 1'b1;
        tick(4);
        total++; if (vcount - vb !== 0) $display("FAIL ena_no_push: got %0d, expected 0", vcount - vb); else passed++;
        total++; if (ferr_n - fb !== 0 || ovr_n - ob !== 0) $display("FAIL ena_pulses: got ferr %0d ovr %0d, expected 0 0", ferr_n - fb, ovr_n - ob); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int vb, pb;
        rx_ready = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        fork
            send_byte(8'hFF, 1'b1);
            begin
                tick(30);
                #1;
                total++; if (busy !== 1'b1 || rx_valid !== 1'b1) $display("FAIL rstmid_before: got busy %b valid %b, expected 1 1", busy, rx_valid); else passed++;
                rst_n = 1'b0;
                #1;
                total++; if (rx_data !== 8'h00) $display("FAIL rstmid_rx_data: got %h, expected 00", rx_data); else passed++;
                total++; if (rx_valid !== 1'b0) $display("FAIL rstmid_rx_valid: got %b, expected 0", rx_valid); else passed++;
                total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b, expected 0", busy); else passed++;
                total++; if (frame_err !== 1'b0 || overrun !== 1'b0) $display("FAIL rstmid_pulses: got %b %b, expected 0 0", frame_err, overrun); else passed++;
                tick(3);
                rst_n = 1'b1;
            end
        join
        rx_ready = 1'b1;
        tick(4);
        vb = vcount; pb = pop_q.size();
        send_byte(8'h42, 1'b1);
        tick(6);
        total++; if (pop_q.size() - pb !== 1 || vcount - vb !== 1) $display("FAIL rstmid_after_count: got pops %0d valid %0d, expected 1 1", pop_q.size() - pb, vcount - vb); else passed++;
        if (pop_q.size() > pb) begin
            total++; if (pop_q[pb] !== 8'h42) $display("FAIL rstmid_after_data: got %h, expected 42", pop_q[pb]); else passed++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_overrun();
        test_frame_error();
        test_glitch();
        test_full_with_pop();
        test_ena_abort();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Serial-to-byte front end inside the Tiny Tapeout user design, directly upstream of the command core.
- Samples an asynchronous UART line taken from a dedicated input pin and frames 8N1 characters.
- Buffers received bytes in a small FIFO and hands them to the core over a valid/ready handshake.
- Also reports framing and overrun errors as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 87, clocks per UART bit; must be >= 4 (87 gives 115200 baud at 10 MHz).
- FIFO_DEPTH, 4, byte FIFO entries; must be a power of two, >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; low aborts any frame in progress.
- rx  in  1  raw asynchronous serial line; idle high.
- rx_data  out  8  byte at the FIFO head.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: good byte dropped because the FIFO was full.
- busy  out  1  framer not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - Framer enters IDLE; FIFO is emptied.
  - rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops reset to 1 (line idle).
- Input sync: rx passes through 2 flops (rx_s). All decisions use rx_s, so detection latency is 2 clk.
- Baud counter: a down-counter of width clog2(CLKS_PER_BIT). Bit index is 3 bits, LSB first.
- Framer states:
  - IDLE: rx_s==0 -> START; counter loaded with CLKS_PER_BIT/2 - 1.
  - START: at counter==0, if rx_s==0 -> DATA (counter=CLKS_PER_BIT-1, bit index=0). If rx_s==1, treat as glitch and return to IDLE; no error is flagged.
  - DATA: at each counter==0, shift rx_s into the MSB of the shift register and reload the counter. After bit index 7 -> STOP.
  - STOP: at counter==0, sample rx_s.
    - rx_s==1: push the byte.
    - rx_s==0: pulse frame_err; byte discarded.
    - Either way -> IDLE.
- Re-arm: IDLE re-arms immediately. If the line is still low after a bad stop bit, a new START begins; this is acceptable.
- ena low: framer forced to IDLE on the next clock; the partial byte is discarded with no pulses. FIFO contents and the read side are unaffected.
- FIFO:
  - Read and write pointers are 1 bit wider than the address; full/empty are derived from the pointers.
  - Push on a good stop. rx_valid rises the cycle after the push (stop sample to rx_valid = 1 clk).
  - Pop on rx_valid && rx_ready. The next entry (or rx_valid=0) appears the following cycle.
  - rx_data and rx_valid are registered and held stable while rx_valid && !rx_ready.
  - Push while full, no pop in the same cycle: byte dropped, overrun pulses for 1 clk, FIFO unchanged.
  - Push while full with a pop in the same cycle: both occur; no overrun.
  - Push while empty: no bypass; the 1-clk latency still applies.
- Pulses:
  - frame_err and overrun are registered and high for exactly one clk per event.
  - The two can never occur in the same cycle.
- Wrap-around: pointers wrap modulo 2*FIFO_DEPTH; a continuous stream runs indefinitely with no stall.

Decomposition:
- Shared package uart_pkg:
  - framer state enum (IDLE, START, DATA, STOP).
  - UART_DATA_W=8.
  - Default CLKS_PER_BIT and FIFO_DEPTH constants.
  - clog2 helper.
- One sub-module: sync_fifo (width, depth parameters; push/pop/full/empty/head).
- Framer and synchronizer stay in uart_rx_frontend.

Test Plan (run at CLKS_PER_BIT=8, FIFO_DEPTH=4):
1. Single frame 0xA5, rx_ready=1 -> rx_valid high for 1 clk with rx_data=0xA5, 1 clk after the stop sample; no error pulses.
2. Five back-to-back frames 0x01..0x05, rx_ready=0 -> FIFO holds 0x01..0x04 and overrun pulses once on the fifth. Raising rx_ready then pops 0x01,0x02,0x03,0x04 on consecutive cycles, after which rx_valid=0.
3. Frame 0x3C with stop bit driven low -> frame_err pulses 1 clk, rx_valid stays 0. A following good frame 0x7E is received correctly.
4. rx low for 3 clk then high (glitch shorter than half a bit) -> framer returns to IDLE, busy falls, nothing pushed, no pulses.
5. FIFO full (4 entries) with rx_ready=1 asserted in the exact cycle of the fifth good stop -> no overrun. All 5 bytes are delivered in order.
6. rst_n asserted mid-DATA of frame 0xFF with 2 bytes queued -> all outputs 0 immediately (asynchronous). After release, a frame 0x42 yields exactly one byte 0x42.
